// File: rtl/enc42_arb.sv
// Registered 4-to-2 request encoder with pending register and valid/ack handshake.
// Define ENC42_RR_EN for round-robin selection; the default is fixed highest-index priority.
module enc42_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [1:0] y,
  output logic       v,
  output logic [3:0] pend,
  output logic       ovf
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state_r;
  logic [1:0] y_r;
  logic       v_r;
  logic [3:0] pend_r;
  logic       ovf_r;
  logic [3:0] set_s;
  logic [3:0] clr_s;
  logic [3:0] pend_next_s;
  logic       ovf_next_s;
  logic [1:0] sel_s;
`ifdef ENC42_RR_EN
  logic [1:0] ptr_r;
`endif

  function automatic logic [3:0] onehot2(input logic [1:0] idx);
    logic [3:0] r;
    r      = 4'b0000;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic [1:0] sel_fixed(input logic [3:0] p);
    logic [1:0] r;
    casez (p)
      4'b1???: r = 2'd3;
      4'b01??: r = 2'd2;
      4'b001?: r = 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

`ifdef ENC42_RR_EN
  // Walk from lowest to highest priority so the last hit (ptr-1) wins.
  function automatic logic [1:0] sel_rr(input logic [3:0] p, input logic [1:0] ptr);
    logic [1:0] r;
    logic [1:0] c;
    r = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      c = ptr - 2'(k);
      if (p[c]) begin
        r = c;
      end
    end
    return r;
  endfunction
`endif

  // Next pending vector, overflow detect and grant selection from the registered pend.
  always_comb begin
    set_s = req & {4{e}};
    if (v_r && ack) begin
      clr_s = onehot2(y_r);
    end else begin
      clr_s = 4'b0000;
    end
    pend_next_s = (pend_r & ~clr_s) | set_s;
    ovf_next_s  = |(set_s & pend_r & ~clr_s);
`ifdef ENC42_RR_EN
    sel_s = sel_rr(pend_r, ptr_r);
`else
    sel_s = sel_fixed(pend_r);
`endif
  end

  // Grant FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      y_r     <= 2'd0;
      v_r     <= 1'b0;
      pend_r  <= 4'b0000;
      ovf_r   <= 1'b0;
`ifdef ENC42_RR_EN
      ptr_r   <= 2'd0;
`endif
    end else begin
      pend_r <= pend_next_s;
      ovf_r  <= ovf_next_s;
      case (state_r)
        IDLE: begin
          if (e && (pend_r != 4'b0000)) begin
            y_r     <= sel_s;
            v_r     <= 1'b1;
            state_r <= HOLD;
          end else begin
            y_r <= 2'd0;
            v_r <= 1'b0;
          end
        end
        HOLD: begin
          // e is deliberately ignored here: an open grant always completes on ack.
          if (ack) begin
            y_r     <= 2'd0;
            v_r     <= 1'b0;
            state_r <= IDLE;
`ifdef ENC42_RR_EN
            ptr_r   <= y_r;
`endif
          end else begin
            y_r <= y_r;
            v_r <= v_r;
          end
        end
        default: begin
          y_r     <= 2'd0;
          v_r     <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign y    = y_r;
  assign v    = v_r;
  assign pend = pend_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_enc42_arb.sv
// Self-checking bench for enc42_arb: directed scenarios plus random traffic
// compared against a request-list reference model.
module tb_enc42_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e;
  logic [3:0] req;
  logic       ack;
  logic [1:0] y;
  logic       v;
  logic [3:0] pend;
  logic       ovf;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Reference model state: which requesters wait, whether a grant is open, and to whom.
  int m_pend[4];
  bit m_busy;
  int m_idx;
  int m_ptr;
  bit m_ovf;

  enc42_arb dut (
    .clk  (clk),
    .rst_n(rst_n),
    .e    (e),
    .req  (req),
    .ack  (ack),
    .y    (y),
    .v    (v),
    .pend (pend),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++) m_pend[b] = 0;
    m_busy = 1'b0;
    m_idx  = 0;
    m_ptr  = 0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the model, using the inputs currently applied.
  task automatic model_edge();
    int served;
    int pick;
    int c;
    bit arrive;
    bit nxt_ovf;
    int nxt_pend[4];
    served = (m_busy && ack) ? m_idx : -1;
    pick   = -1;
    if (!m_busy && e) begin
`ifdef ENC42_RR_EN
      for (int off = 1; off <= 4; off++) begin
        c = (m_ptr + 4 - off) % 4;
        if (pick < 0 && m_pend[c] != 0) pick = c;
      end
`else
      for (int b = 3; b >= 0; b--) begin
        if (pick < 0 && m_pend[b] != 0) pick = b;
      end
`endif
    end
    nxt_ovf = 1'b0;
    for (int b = 0; b < 4; b++) begin
      arrive = e && req[b];
      if (arrive && m_pend[b] != 0 && b != served) nxt_ovf = 1'b1;
      nxt_pend[b] = arrive ? 1 : ((b == served) ? 0 : m_pend[b]);
    end
    if (m_busy && ack) begin
      m_busy = 1'b0;
      m_ptr  = m_idx;
    end else if (pick >= 0) begin
      m_busy = 1'b1;
      m_idx  = pick;
    end
    for (int b = 0; b < 4; b++) m_pend[b] = nxt_pend[b];
    m_ovf = nxt_ovf;
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] ep;
    for (int b = 0; b < 4; b++) ep[b] = (m_pend[b] != 0);
    chk({tag, ".v"}, 32'(v), 32'(m_busy));
    chk({tag, ".y"}, 32'(y), m_busy ? 32'(m_idx) : 32'd0);
    chk({tag, ".pend"}, 32'(pend), 32'(ep));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    e     = 1'b0;
    req   = 4'b0000;
    ack   = 1'b0;
    model_reset();
    #3;
    chk("rst.v", 32'(v), 32'd0);
    chk("rst.y", 32'(y), 32'd0);
    chk("rst.pend", 32'(pend), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request with ack.
    e = 1'b1; req = 4'b0100;
    tick("single_cap");
    chk("single_cap.pend", 32'(pend), 32'h4);
    chk("single_cap.v", 32'(v), 32'd0);
    req = 4'b0000;
    tick("single_grant");
    chk("single_grant.v", 32'(v), 32'd1);
    chk("single_grant.y", 32'(y), 32'd2);
    tick("single_hold");
    ack = 1'b1;
    tick("single_ack");
    chk("single_ack.v", 32'(v), 32'd0);
    chk("single_ack.pend", 32'(pend), 32'd0);
    ack = 1'b0;

    // Asynchronous reset in the middle of a HOLD with y=2.
    req = 4'b0100;
    tick("arst_cap");
    req = 4'b0000;
    tick("arst_grant");
    chk("arst_pre.y", 32'(y), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.v", 32'(v), 32'd0);
    chk("arst.y", 32'(y), 32'd0);
    chk("arst.pend", 32'(pend), 32'd0);
    chk("arst.ovf", 32'(ovf), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick("arst_rel");

`ifndef ENC42_RR_EN
    // Fixed priority: one burst of 1011 drained with ack held high.
    req = 4'b1011;
    tick("fp_cap");
    req = 4'b0000;
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("fp_grant");
      chk("fp_grant.v", 32'(v), 32'd1);
      chk("fp_grant.y", 32'(y), (i == 0) ? 32'd3 : ((i == 1) ? 32'd1 : 32'd0));
      tick("fp_gap");
      chk("fp_gap.v", 32'(v), 32'd0);
    end
    tick("fp_idle");
    chk("fp_idle.v", 32'(v), 32'd0);
`else
    // Round-robin: 1001 held high with ack held high alternates 3,0.
    req = 4'b1001;
    ack = 1'b1;
    tick("rr_cap");
    for (int i = 0; i < 4; i++) begin
      tick("rr_grant");
      chk("rr_grant.v", 32'(v), 32'd1);
      chk("rr_grant.y", 32'(y), (i % 2 == 0) ? 32'd3 : 32'd0);
      tick("rr_gap");
      chk("rr_gap.v", 32'(v), 32'd0);
    end
    req = 4'b0000;
    for (int i = 0; i < 6; i++) tick("rr_drain");
`endif
    ack = 1'b0;
    req = 4'b0000;
    tick("mid_idle");

    // Set wins over clear, and overflow while held.
    req = 4'b0010;
    tick("sw_cap");
    req = 4'b0000;
    tick("sw_grant");
    chk("sw_grant.y", 32'(y), 32'd1);
    req = 4'b0010; ack = 1'b1;
    tick("sw_setclr");
    chk("sw_setclr.pend", 32'(pend), 32'h2);
    chk("sw_setclr.ovf", 32'(ovf), 32'd0);
    chk("sw_setclr.v", 32'(v), 32'd0);
    req = 4'b0000; ack = 1'b0;
    tick("ov_grant");
    req = 4'b0010;
    tick("ov_hit");
    chk("ov_hit.ovf", 32'(ovf), 32'd1);
    req = 4'b0000;
    tick("ov_after");
    chk("ov_after.ovf", 32'(ovf), 32'd0);
    ack = 1'b1;
    tick("ov_ack");
    ack = 1'b0;

    // Enable gating.
    req = 4'b0001;
    tick("en_cap");
    e = 1'b0; req = 4'b1111;
    tick("en_off");
    chk("en_off.pend", 32'(pend), 32'h1);
    chk("en_off.v", 32'(v), 32'd0);
    tick("en_off2");
    e = 1'b1; req = 4'b0000;
    tick("en_grant");
    chk("en_grant.y", 32'(y), 32'd0);
    chk("en_grant.v", 32'(v), 32'd1);
    e = 1'b0; ack = 1'b1;
    tick("en_hold_ack");
    chk("en_hold_ack.v", 32'(v), 32'd0);
    chk("en_hold_ack.pend", 32'(pend), 32'd0);
    e = 1'b1; ack = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      e   = ($urandom_range(0, 3) != 0);
      req = 4'($urandom) & 4'($urandom);
      ack = 1'($urandom_range(0, 1));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/enc42_arb.md
# enc42_arb

Registered 4-to-2 request encoder with valid/ack handshake: the inverse of the team's 2-to-4 decoder. Requesters raise bits on a 4-bit request bus. The block latches them into a pending register and encodes one pending bit at a time into a 2-bit index `y`. It holds `y` with `v` until the consumer acknowledges, then clears the served bit. Its 2-bit index feeds the 2-to-4 decoder in the select path, closing the loop from request back to one-hot enable.

## Interface
- No parameters; widths are fixed at 4 requests and a 2-bit index.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `e` input 1: enable; gates capture of new requests and the start of new grants.
- `req` input 4: request bits; a bit that is high on an edge with `e`=1 is latched.
- `ack` input 1: consumer acknowledge; only meaningful while `v`=1.
- `y` output 2: encoded index of the granted request; 2'b00 whenever `v`=0.
- `v` output 1: grant valid.
- `pend` output 4: pending-request register, directly visible.
- `ovf` output 1: one-cycle pulse; a request arrived for a bit that was already pending and is not being cleared this edge.

## Operation
- Reset (async, `rst_n`=0):
  - `y`=2'b00, `v`=0, `pend`=4'b0000, `ovf`=0.
  - State IDLE; round-robin pointer `ptr`=2'd0.
- Capture on every edge: `pend_next = (pend & ~clr) | (req & {4{e}})`.
  - `clr` is the one-hot of `y` when `v`=1 and `ack`=1, else 0.
  - If set and clear hit the same bit on the same edge, set wins: the bit stays pending.
- `ovf_next = |(req & {4{e}} & pend & ~clr)`.
- State IDLE:
  - If `e`=1 and `pend`≠0, load `y` = selected index, set `v`=1, go to HOLD.
  - Otherwise keep `v`=0 and `y`=00.
  - Selection uses the registered `pend`, not the `req` bits arriving on the same edge.
- State HOLD:
  - `y` and `v` are held stable regardless of `e`, `req` or `pend` changes.
  - On `ack`=1: clear `pend[y]` (subject to the set-wins rule), set `v`=0, `y`=00, go to IDLE.
  - With RR enabled, also set `ptr`=`y` on `ack`=1.
  - `e`=0 during HOLD does not abort the grant; the pending grant still completes on `ack`.
- Default selection is fixed priority: highest index wins (3 > 2 > 1 > 0).
- `ack` while `v`=0 is ignored and clears nothing.

## Timing
- `req` sampled at edge k → `pend` updated after edge k → `v`=1 after edge k+1 (2-edge latency from sampling to grant).
- `ack` sampled high at edge m → `v`=0 and `pend` bit cleared after edge m.
- The earliest next `v`=1 is after edge m+1, giving a maximum throughput of one grant per 2 cycles.
- `ack` held high continuously gives one grant every 2 cycles while requests remain pending.
- `ovf` is registered: it is high for exactly the cycle after the offending edge.
- Outputs are fully registered; there is no combinational path from any input to `y`, `v`, `pend` or `ovf`.

## Configuration
- Macro `ENC42_RR_EN`.
- Defined: round-robin selection.
  - Search order is `ptr`-1, `ptr`-2, `ptr`-3, `ptr` (mod 4), descending.
  - `ptr` updates to the granted index on `ack`.
  - Reset `ptr`=0 gives order 3,2,1,0, identical to fixed priority for the first grant.
- Undefined: fixed highest-index priority.
  - `ptr` logic is not compiled in.
  - `ack` has no effect on selection order.

## Test plan
- Reset value check: assert `rst_n`=0 mid-HOLD with `y`=2'b10 → all outputs go to 0 immediately and asynchronously; after release, `pend`=0000 and `v`=0.
- Single request: `e`=1, `req`=0100 for 1 cycle at edge k → `pend`=0100 after k; `v`=1, `y`=2'b10 after k+1; `ack` at edge m → `v`=0, `y`=00, `pend`=0000 after m.
- Fixed priority (macro undefined): `req`=1011 once, `ack` held high → grants `y`=3,1,0 on alternate cycles, then `v` stays 0.
- Round-robin (`ENC42_RR_EN`): `req`=1001 held high with `ack` held high → grants alternate 3,0,3,0.
- Set-wins / overflow:
  - `req`=0010 held while `v`=1, `y`=01, `ack`=1 → `pend[1]` remains 1, `ovf` stays 0 (clear and set on the same edge is not overflow).
  - `req`=0010 asserted again in HOLD without `ack` → `ovf`=1 for exactly 1 cycle.
- Enable gating: `e`=0 with `req`=1111 → `pend` is unchanged and no new grant starts; `e`=0 during HOLD with `ack`=1 → the grant still completes and clears.
